// File: rtl/fetch_cycle_bp_pkg.sv
// Shared fetch-pipeline definitions: bubble constant, counter encodings, F/D record.
package fetch_cycle_bp_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_BUBBLE       = 32'h0000_0000;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcPlus4;
    logic        pred;
    logic [31:0] predPc;
  } fdReg_t;

  function automatic ctr_e ctrNext(input ctr_e c, input logic taken);
    if (taken) return (c == CTR_ST) ? CTR_ST : ctr_e'(c + 2'b01);
    return (c == CTR_SNT) ? CTR_SNT : ctr_e'(c - 2'b01);
  endfunction

endpackage

// File: rtl/fetch_cycle_bp_btb_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters; lookup is combinational,
// update is registered so a same-cycle lookup sees the old entry.
module btb_predictor
  import fetch_cycle_bp_pkg::*;
#(
  parameter int BTB_ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] lookupPc,
  output logic        predTaken,
  output logic [31:0] predTarget,
  input  logic        updEn,
  input  logic        updTaken,
  input  logic [31:0] updPc,
  input  logic [31:0] updTarget
);

  localparam int IDXW = $clog2(BTB_ENTRIES);
  localparam int TAGW = 30 - IDXW;

  logic              validQ  [BTB_ENTRIES];
  logic [TAGW-1:0]   tagQ    [BTB_ENTRIES];
  logic [31:0]       targetQ [BTB_ENTRIES];
  ctr_e              ctrQ    [BTB_ENTRIES];

  logic [IDXW-1:0] lkIdx, updIdx;
  logic [TAGW-1:0] lkTag, updTag;
  logic [1:0]      lkCtr;
  logic            lkHit, updHit;
  logic [3:0]      unusedLowBits;

  assign lkIdx  = lookupPc[IDXW+1:2];
  assign lkTag  = lookupPc[31:IDXW+2];
  assign updIdx = updPc[IDXW+1:2];
  assign updTag = updPc[31:IDXW+2];
  assign unusedLowBits = {lookupPc[1:0], updPc[1:0]};

  assign lkCtr      = ctrQ[lkIdx];
  assign lkHit      = validQ[lkIdx] && (tagQ[lkIdx] == lkTag);
  assign predTaken  = lkHit && lkCtr[1];
  assign predTarget = targetQ[lkIdx];

  assign updHit = validQ[updIdx] && (tagQ[updIdx] == updTag);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        validQ[i]  <= 1'b0;
        tagQ[i]    <= '0;
        targetQ[i] <= '0;
        ctrQ[i]    <= CTR_WNT;
      end
    end else if (updEn) begin
      if (updHit) begin
        ctrQ[updIdx] <= ctrNext(ctrQ[updIdx], updTaken);
        if (updTaken) targetQ[updIdx] <= updTarget;
      end else if (updTaken) begin
        // Only taken branches earn an entry; fresh entries start weakly taken.
        validQ[updIdx]  <= 1'b1;
        tagQ[updIdx]    <= updTag;
        targetQ[updIdx] <= updTarget;
        ctrQ[updIdx]    <= CTR_WT;
      end
    end
  end

endmodule

// File: rtl/fetch_cycle_bp.sv
// Fetch stage: PC select with BTB prediction, and the F/D pipeline register.
module fetch_cycle_bp
  import fetch_cycle_bp_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int          BTB_ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        RedirectE,
  input  logic [31:0] RedirectPCE,
  input  logic        BranchE,
  input  logic        TakenE,
  input  logic [31:0] PCE,
  input  logic [31:0] PCTargetE,
  output logic [31:0] IMemAddrF,
  input  logic [31:0] IMemRdataF,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        PredictionD,
  output logic [31:0] PredictedPCD
);

  localparam fdReg_t FD_BUBBLE = '{instr: NOP_BUBBLE, pc: '0, pcPlus4: '0,
                                   pred: 1'b0, predPc: '0};

  logic [31:0] pcF, pcPlus4F, predTargetF, predNextF, nextPcF;
  logic        predTakenF;
  fdReg_t      fdQ;

  btb_predictor #(.BTB_ENTRIES(BTB_ENTRIES)) uBtb (
    .clk       (clk),
    .rst       (rst),
    .lookupPc  (pcF),
    .predTaken (predTakenF),
    .predTarget(predTargetF),
    .updEn     (BranchE),
    .updTaken  (TakenE),
    .updPc     (PCE),
    .updTarget (PCTargetE)
  );

  assign pcPlus4F  = pcF + 32'd4;
  assign predNextF = predTakenF ? predTargetF : pcPlus4F;

  // A redirect must win over a stall or the mispredicted path never drains.
  always_comb begin
    nextPcF = predNextF;
    if (RedirectE)   nextPcF = RedirectPCE;
    else if (StallF) nextPcF = pcF;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pcF <= RESET_PC;
    else     pcF <= nextPcF;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       fdQ <= FD_BUBBLE;
    else if (FlushD || RedirectE)  fdQ <= FD_BUBBLE;
    else if (!StallD)              fdQ <= '{instr: IMemRdataF, pc: pcF, pcPlus4: pcPlus4F,
                                            pred: predTakenF, predPc: predNextF};
  end

  assign IMemAddrF    = pcF;
  assign InstrD       = fdQ.instr;
  assign PCD          = fdQ.pc;
  assign PCPlus4D     = fdQ.pcPlus4;
  assign PredictionD  = fdQ.pred;
  assign PredictedPCD = fdQ.predPc;

endmodule
